// File: rtl/fp_mul_arbiter.sv
// Round-robin front end for a single shared, fully pipelined modular multiplier.
// Issues at most one operand pair per cycle, carries the requester ID alongside
// the multiplier pipeline, and steers each product back to its owner.
module fp_mul_arbiter #(
  parameter int N_REQ       = 4,
  parameter int W           = 255,
  parameter int LATENCY_MUL = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [W-1:0]       mul_a,
  output logic [W-1:0]       mul_b,
  input  logic [W-1:0]       mul_d,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [2:0]         rsp_id,
  output logic [W-1:0]       rsp_data,
  output logic [3:0]         in_flight
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Tag stage k holds the issue from k edges ago; the last stage lines up
  // with the cycle in which mul_d carries that operation's product.
  localparam int DEPTH = LATENCY_MUL + 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] grant;
  logic [2:0]       grant_id;
  logic             hs;

  logic [W-1:0]     mul_a_q, mul_a_d;
  logic [W-1:0]     mul_b_q, mul_b_d;
  logic [DEPTH-1:0] tag_vld_q;
  logic [2:0]       tag_id_q [DEPTH];

  logic             ret_vld;
  logic [2:0]       ret_id;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [2:0]       rsp_id_q;
  logic [W-1:0]     rsp_data_q;
  logic [3:0]       in_flight_q, in_flight_d;

  // Round-robin search starting at ptr; the first valid index wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    // NOTE: every output of this block gets a default first so that no path
    // leaves a value unassigned, which would otherwise infer a latch.
    grant    = '0;
    grant_id = '0;
    hs       = 1'b0;
    idx      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = PTR_W'((int'(ptr_q) + i) % N_REQ);
      if (!hs && req_valid[idx]) begin
        hs          = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = 3'(idx);
      end
    end
    if (rst) begin
      grant = '0;
      hs    = 1'b0;
    end
  end

  assign req_ready = grant;

  // Next-state for pointer, issue registers, response and occupancy counter.
  always_comb begin
    ptr_d = ptr_q;
    if (hs) begin
      ptr_d = (grant_id == 3'(N_REQ - 1)) ? '0 : PTR_W'(grant_id) + PTR_W'(1);
    end

    mul_a_d = hs ? req_a[grant_id*W +: W] : '0;
    mul_b_d = hs ? req_b[grant_id*W +: W] : '0;

    ret_vld     = tag_vld_q[DEPTH-1];
    ret_id      = tag_id_q[DEPTH-1];
    rsp_valid_d = ret_vld ? (N_REQ'(1) << ret_id) : '0;

    // An operation counts as in flight from its handshake edge until the
    // edge that registers its response.
    unique case ({hs, ret_vld})
      2'b10:   in_flight_d = in_flight_q + 4'd1;
      2'b01:   in_flight_d = in_flight_q - 4'd1;
      default: in_flight_d = in_flight_q;
    endcase
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      ptr_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tag_vld_q   <= '0;
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      in_flight_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      tag_vld_q   <= {tag_vld_q[DEPTH-2:0], hs};
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= ret_id;
      rsp_data_q  <= mul_d;
      in_flight_q <= in_flight_d;
    end
  end

  // Tag ID shift register, advancing every cycle alongside the valid bits.
  always_ff @(posedge clk) begin
    // NOTE: the ID storage is deliberately not reset; an ID is only ever
    // consumed together with its valid bit, and that bit is cleared on reset.
    tag_id_q[0] <= grant_id;
    for (int k = 1; k < DEPTH; k++) begin
      tag_id_q[k] <= tag_id_q[k-1];
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign in_flight = in_flight_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: drives requesters, models the external multiplier
// (modulo 2^255-19) and checks every response through an in-order scoreboard.
module tb_fp_mul_arbiter;

  localparam int N   = 4;
  localparam int W   = 255;
  localparam int LAT = 6;
  localparam logic [W-1:0] P = {{250{1'b1}}, 5'b01101};

  logic             clk;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_a, req_b;
  logic [N-1:0]     req_ready;
  logic [W-1:0]     mul_a, mul_b, mul_d;
  logic [N-1:0]     rsp_valid;
  logic [2:0]       rsp_id;
  logic [W-1:0]     rsp_data;
  logic [3:0]       in_flight;

  fp_mul_arbiter #(.N_REQ(N), .W(W), .LATENCY_MUL(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_d(mul_d),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .in_flight(in_flight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] prod, m;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    m    = prod % {{W{1'b0}}, P};
    return m[W-1:0];
  endfunction

  // Stand-in for the external multiplier: captures A/B and presents D
  // LAT edges later.
  logic [W-1:0] mpipe [LAT];
  always_ff @(posedge clk) begin
    mpipe[0] <= mod_mul(mul_a, mul_b);
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_d = mpipe[LAT-1];

  typedef struct {
    logic [2:0]   id;
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  typedef struct {
    logic [N-1:0] vld;
    logic [N-1:0] exp_ready;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   n_resp   = 0;
  int   max_if   = 0;

  logic [N-1:0] s_ready, s_rsp_valid;
  logic [W-1:0] s_mul_a, s_mul_b;
  logic [2:0]   s_rsp_id;
  logic [3:0]   s_in_flight;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r[W-1:0];
  endfunction

  task automatic rand_ops();
    for (int r = 0; r < N; r++) begin
      req_a[r*W +: W] = rnd();
      req_b[r*W +: W] = rnd();
    end
  endtask

  // One clock cycle: sample at the falling edge, score responses, record
  // handshakes, then advance past the rising edge.
  task automatic tick();
    exp_t         e;
    logic [N-1:0] hsv;
    @(negedge clk);
    s_ready     = req_ready;
    s_rsp_valid = rsp_valid;
    s_rsp_id    = rsp_id;
    s_mul_a     = mul_a;
    s_mul_b     = mul_b;
    s_in_flight = in_flight;
    if (int'(in_flight) > max_if) max_if = int'(in_flight);
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      check("rsp_missing_cycle", W'(cyc), W'(sb[0].cyc));
      e = sb.pop_front();
    end
    if (rsp_valid !== '0) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", W'(rsp_valid), '0);
      end else begin
        e = sb.pop_front();
        n_resp++;
        check("rsp_valid", W'(rsp_valid), W'(N'(1) << e.id));
        check("rsp_id", W'(rsp_id), W'(e.id));
        check("rsp_data", rsp_data, e.data);
        check("rsp_cycle", W'(cyc), W'(e.cyc));
      end
    end
    if (rst) begin
      sb.delete();
    end else begin
      hsv = req_valid & req_ready;
      for (int r = 0; r < N; r++) begin
        if (hsv[r]) sb.push_back('{3'(r), mod_mul(req_a[r*W +: W], req_b[r*W +: W]), cyc + 8});
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  localparam int NV = 20;
  vec_t vecs [NV];

  initial begin
    int resp0;

    // Pointer is 3 on entry (single request went to index 2).
    vecs[0]  = '{4'b1111, 4'b1000};
    vecs[1]  = '{4'b1111, 4'b0001};
    vecs[2]  = '{4'b1111, 4'b0010};
    vecs[3]  = '{4'b1111, 4'b0100};
    vecs[4]  = '{4'b1111, 4'b1000};
    vecs[5]  = '{4'b1111, 4'b0001};
    vecs[6]  = '{4'b1111, 4'b0010};
    vecs[7]  = '{4'b0001, 4'b0001};
    vecs[8]  = '{4'b1001, 4'b1000};
    vecs[9]  = '{4'b1001, 4'b0001};
    vecs[10] = '{4'b1001, 4'b1000};
    vecs[11] = '{4'b1001, 4'b0001};
    vecs[12] = '{4'b0000, 4'b0000};
    vecs[13] = '{4'b0110, 4'b0010};
    vecs[14] = '{4'b0110, 4'b0100};
    vecs[15] = '{4'b0110, 4'b0010};
    vecs[16] = '{4'b1000, 4'b1000};
    vecs[17] = '{4'b0101, 4'b0001};
    vecs[18] = '{4'b0101, 4'b0100};
    vecs[19] = '{4'b0101, 4'b0001};

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;

    // Reset state, including req_ready held low while rst is asserted.
    tick();
    tick();
    req_valid = 4'b1111;
    rand_ops();
    tick();
    check("reset_ready", W'(s_ready), '0);
    check("reset_mul_a", mul_a, '0);
    check("reset_mul_b", mul_b, '0);
    check("reset_rsp_valid", W'(rsp_valid), '0);
    check("reset_rsp_id", W'(rsp_id), '0);
    check("reset_rsp_data", rsp_data, '0);
    check("reset_in_flight", W'(in_flight), '0);
    req_valid = '0;
    rst       = 1'b0;
    tick();

    // Single request from requester 2 with fixed operands.
    req_a = '0;
    req_b = '0;
    req_a[2*W +: W] = 255'h3807ed85e85d8b3fbd5a293a18bb42f0912b8e383d833a9a269d132d5a5167b;
    req_b[2*W +: W] = 255'h253416b9fd917c11bf5458e3d2c49838944c136207a995c61be3db3c0a843f;
    req_valid = 4'b0100;
    tick();
    check("single_ready", W'(s_ready), W'(4'b0100));
    req_valid = '0;
    for (int k = 0; k < 7; k++) begin
      tick();
      check($sformatf("single_in_flight[%0d]", k), W'(s_in_flight), W'(1));
      if (k == 0) check("single_mul_a", s_mul_a,
                        255'h3807ed85e85d8b3fbd5a293a18bb42f0912b8e383d833a9a269d132d5a5167b);
    end
    tick();
    check("single_rsp_valid", W'(s_rsp_valid), W'(4'b0100));
    check("single_rsp_id", W'(s_rsp_id), W'(2));
    for (int k = 0; k < 3; k++) tick();

    // Table-driven arbitration: all requesting, pointer skip, idle gaps.
    max_if = 0;
    for (int i = 0; i < NV; i++) begin
      req_valid = vecs[i].vld;
      rand_ops();
      tick();
      check($sformatf("grant[%0d]", i), W'(s_ready), W'(vecs[i].exp_ready));
    end
    req_valid = '0;
    for (int k = 0; k < 10; k++) tick();
    check("in_flight_peak", W'(max_if), W'(LAT + 1));

    // Back-to-back operations from requester 1 alone.
    resp0 = n_resp;
    req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      rand_ops();
      tick();
      check($sformatf("b2b_ready[%0d]", k), W'(s_ready), W'(4'b0010));
    end
    req_valid = '0;
    for (int k = 0; k < 10; k++) tick();
    check("b2b_resp_count", W'(n_resp - resp0), W'(3));

    // Reset while three operations are in flight (pointer would be 1).
    req_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      rand_ops();
      tick();
    end
    req_valid = '0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("abort_in_flight", W'(s_in_flight), '0);
    for (int k = 0; k < 10; k++) tick();
    req_valid = 4'b1001;
    rand_ops();
    tick();
    check("abort_ptr_grant", W'(s_ready), W'(4'b0001));
    req_valid = '0;
    for (int k = 0; k < 10; k++) tick();

    // Idle: nothing issued, nothing returned.
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("idle_mul_a[%0d]", k), s_mul_a, '0);
      check($sformatf("idle_mul_b[%0d]", k), s_mul_b, '0);
      check($sformatf("idle_rsp_valid[%0d]", k), W'(s_rsp_valid), '0);
      check($sformatf("idle_in_flight[%0d]", k), W'(s_in_flight), '0);
    end

    check("scoreboard_drained", W'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
